// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract engine around one full-adder cell.
// Processes one bit pair per clock, LSB first; a WIDTH-bit operation takes
// WIDTH cycles between acceptance and result.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready high only in IDLE)
//   a, b, sub               operands; sub=1 computes a + ~b + 1
//   out_valid/out_ready     result handshake (out_valid high only in DONE)
//   sum, cout, ovf          result, final carry, two's-complement overflow
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;

    // The single full-adder cell.
    assign fa_s = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    cnt_d   = cnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns number of edges waited.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            step();
            edges++;
        end
    endtask

    // Accept one operand set, check latency and result; handshake if out_ready is high.
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic s_v, input logic [7:0] es, input logic ec, input logic eo);
        int edges;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = a_v;
        b        = b_v;
        sub      = s_v;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_done(edges);
        check({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        if (out_ready) begin
            step();
            check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int edges;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub3333", 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("sub00ff", 8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b0);

        // Back-pressure: DONE held for 20 cycles.
        out_ready = 1'b0;
        run_op("bp", 8'hA5, 8'h0F, 1'b0, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'hB4);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_ovf", 32'(ovf), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_vld", 32'(out_valid), 32'd0);
        check("bp_release_rdy", 32'(in_ready), 32'd1);

        // in_valid held with changing operands during RUN must be ignored.
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        sub      = 1'b0;
        out_ready = 1'b0;
        step();
        edges = 0;
        while (!out_valid && edges < 50) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom);
            step();
            edges++;
        end
        in_valid = 1'b0;
        check("ign_latency", 32'(edges), 32'(WIDTH));
        check("ign_sum", 32'(sum), 32'h46);
        check("ign_cout", 32'(cout), 32'd0);
        check("ign_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            check("ign_single_result", 32'(out_valid), 32'd0);
            check("ign_idle", 32'(in_ready), 32'd1);
            step();
        end

        // Reset in the middle of RUN discards the operation.
        in_valid = 1'b1;
        a        = 8'hC3;
        b        = 8'h5A;
        sub      = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("mrst_no_result", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
